// File: rtl/display_scan_if.sv
// Bundle between the timekeeping logic and the display scan controller.
// The master drives digit data and scan enable; the slave drives the pad-facing outputs.
interface display_scan_if;
    logic        en;
    logic [31:0] digits;
    logic [7:0]  dp_mask;
    logic [7:0]  blink_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  disp_en;
    logic        frame_start;

    modport master (
        output en, digits, dp_mask, blink_mask,
        input  seg, dp, disp_en, frame_start
    );

    modport slave (
        input  en, digits, dp_mask, blink_mask,
        output seg, dp, disp_en, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with frame snapshots,
// anti-ghost blanking, leading-zero suppression and per-digit blink.
module display_scan_ctrl #(
    parameter int       PRESCALE     = 1000,
    parameter int       BLANK        = 16,
    parameter int       BLINK_FRAMES = 64,
    parameter bit [7:0] LZ_MASK      = 8'h80,
    parameter bit       SEG_ACT_LOW  = 1'b0,
    parameter bit       EN_ACT_LOW   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    display_scan_if.slave bus
);
    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int FR_W  = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0] SEG_IDLE = {7{SEG_ACT_LOW}};
    localparam logic       DP_IDLE  = SEG_ACT_LOW;
    localparam logic [7:0] EN_IDLE  = {8{EN_ACT_LOW}};

    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] s;
        case (val)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [FR_W-1:0]  fcnt;
    logic             blink_ph;
    logic [31:0]      sh_digits;
    logic [7:0]       sh_dp;
    logic [7:0]       sh_blink;

    logic             dwell_end;
    logic             frame_end;

    assign dwell_end = (cnt == CNT_W'(PRESCALE - 1));
    assign frame_end = dwell_end && (idx == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            fcnt      <= '0;
            blink_ph  <= 1'b0;
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blink  <= '0;
        end else if (bus.en) begin
            cnt <= dwell_end ? '0 : cnt + 1'b1;
            if (dwell_end) begin
                idx <= idx + 3'd1;
            end
            // Snapshot only at the frame boundary so a frame never tears
            if (frame_end) begin
                sh_digits <= bus.digits;
                sh_dp     <= bus.dp_mask;
                sh_blink  <= bus.blink_mask;
                if (fcnt == FR_W'(BLINK_FRAMES - 1)) begin
                    fcnt     <= '0;
                    blink_ph <= ~blink_ph;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // Stage p0: combinational digit selection and decode from current (cnt, idx)
    logic [3:0] val_p0;
    logic       blank_p0;
    logic [6:0] seg_p0;
    logic       dp_p0;
    logic [7:0] en_p0;

    always_comb begin
        val_p0   = sh_digits[{idx, 2'b00} +: 4];
        blank_p0 = (blink_ph && sh_blink[idx]) || (LZ_MASK[idx] && (val_p0 == 4'd0));
        seg_p0   = blank_p0 ? 7'd0 : seg_decode(val_p0);
        dp_p0    = !blank_p0 && sh_dp[idx];
        en_p0    = '0;
        if (!blank_p0 && (cnt >= CNT_W'(BLANK))) begin
            en_p0[idx] = 1'b1;
        end
    end

    // Stage p1: registered pad outputs with polarity applied
    logic [6:0] seg_p1;
    logic       dp_p1;
    logic [7:0] en_p1;
    logic       fs_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p1 <= SEG_IDLE;
            dp_p1  <= DP_IDLE;
            en_p1  <= EN_IDLE;
            fs_p1  <= 1'b0;
        end else if (bus.en) begin
            seg_p1 <= seg_p0 ^ SEG_IDLE;
            dp_p1  <= dp_p0 ^ DP_IDLE;
            en_p1  <= en_p0 ^ EN_IDLE;
            fs_p1  <= frame_end;
        end else begin
            seg_p1 <= SEG_IDLE;
            dp_p1  <= DP_IDLE;
            en_p1  <= EN_IDLE;
            fs_p1  <= 1'b0;
        end
    end

    assign bus.seg         = seg_p1;
    assign bus.dp          = dp_p1;
    assign bus.disp_en     = en_p1;
    assign bus.frame_start = fs_p1;
endmodule
